// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: valid/ready request in, one-cycle response strobe out.
// Storage is zeroed word by word after every reset before the first request is accepted.
module data_mem_responder #(
    parameter int AW      = 6,
    parameter int LATENCY = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        word_we,
    input  logic        byte_we,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_BUSY  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   lat_addr_q, lat_addr_d;
    logic [31:0]   lat_wdata_q, lat_wdata_d;
    logic          lat_word_we_q, lat_word_we_d;
    logic          lat_byte_we_q, lat_byte_we_d;
    logic          req_ready_q, req_ready_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          addr_err_q, addr_err_d;

    logic [31:0]   mem_q [2**AW];

    logic          accept_s;
    logic          commit_s;
    logic [31:0]   cur_addr_s;
    logic [31:0]   cur_wdata_s;
    logic          cur_word_we_s;
    logic          cur_byte_we_s;
    logic          in_range_s;
    logic [AW-1:0] widx_s;
    logic [31:0]   merged_s;
    logic          mem_we_s;
    logic [AW-1:0] mem_widx_s;
    logic [31:0]   mem_wdata_s;

    function automatic logic [31:0] merge_store(
        input logic [31:0] old_w,
        input logic [31:0] din,
        input logic        w_we,
        input logic        b_we,
        input logic [1:0]  lane
    );
        logic [31:0] res;
        res = old_w;
        if (w_we) begin
            res = din;
        end else if (b_we) begin
            case (lane)
                2'd0:    res[7:0]   = din[7:0];
                2'd1:    res[15:8]  = din[7:0];
                2'd2:    res[23:16] = din[7:0];
                2'd3:    res[31:24] = din[7:0];
                default: res        = old_w;
            endcase
        end else begin
            res = old_w;
        end
        return res;
    endfunction

    // Next-state, commit and registered-output computation.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        lat_addr_d    = lat_addr_q;
        lat_wdata_d   = lat_wdata_q;
        lat_word_we_d = lat_word_we_q;
        lat_byte_we_d = lat_byte_we_q;
        rdata_d       = rdata_q;
        addr_err_d    = 1'b0;
        commit_s      = 1'b0;
        mem_we_s      = 1'b0;
        mem_widx_s    = idx_q;
        mem_wdata_s   = 32'd0;
        accept_s      = req_valid && req_ready_q;

        // With LATENCY=1 the commit edge is also the acceptance edge, so use live inputs.
        if (state_q == ST_IDLE) begin
            cur_addr_s    = addr;
            cur_wdata_s   = wdata;
            cur_word_we_s = word_we;
            cur_byte_we_s = byte_we;
        end else begin
            cur_addr_s    = lat_addr_q;
            cur_wdata_s   = lat_wdata_q;
            cur_word_we_s = lat_word_we_q;
            cur_byte_we_s = lat_byte_we_q;
        end

        in_range_s = (cur_addr_s[31:AW+2] == '0);
        widx_s     = cur_addr_s[AW+1:2];
        merged_s   = merge_store(mem_q[widx_s], cur_wdata_s, cur_word_we_s,
                                 cur_byte_we_s, cur_addr_s[1:0]);

        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_widx_s  = idx_q;
                mem_wdata_s = 32'd0;
                idx_d       = idx_q + AW'(1);
                if (idx_q == '1) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    lat_addr_d    = addr;
                    lat_wdata_d   = wdata;
                    lat_word_we_d = word_we;
                    lat_byte_we_d = byte_we;
                    if (LATENCY == 1) begin
                        state_d  = ST_RESP;
                        commit_s = 1'b1;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = 4'(LATENCY - 2);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == 4'd0) begin
                    state_d  = ST_RESP;
                    commit_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
                idx_d   = '0;
            end
        endcase

        if (commit_s) begin
            if (in_range_s) begin
                if (cur_word_we_s || cur_byte_we_s) begin
                    mem_we_s    = 1'b1;
                    mem_widx_s  = widx_s;
                    mem_wdata_s = merged_s;
                end else begin
                    mem_we_s = 1'b0;
                end
                rdata_d    = merged_s;
                addr_err_d = 1'b0;
            end else begin
                rdata_d    = 32'd0;
                addr_err_d = 1'b1;
            end
        end else begin
            addr_err_d = 1'b0;
        end

        req_ready_d  = (state_d == ST_IDLE);
        resp_valid_d = (state_d == ST_RESP);
    end

    // State, latched request, outputs and storage; reset aborts any pending write.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_CLEAR;
            idx_q         <= '0;
            cnt_q         <= 4'd0;
            lat_addr_q    <= 32'd0;
            lat_wdata_q   <= 32'd0;
            lat_word_we_q <= 1'b0;
            lat_byte_we_q <= 1'b0;
            req_ready_q   <= 1'b0;
            resp_valid_q  <= 1'b0;
            rdata_q       <= 32'd0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            lat_addr_q    <= lat_addr_d;
            lat_wdata_q   <= lat_wdata_d;
            lat_word_we_q <= lat_word_we_d;
            lat_byte_we_q <= lat_byte_we_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            rdata_q       <= rdata_d;
            addr_err_q    <= addr_err_d;
            if (mem_we_s) begin
                mem_q[mem_widx_s] <= mem_wdata_s;
            end
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=3 instance for most checks and a
// LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, word_we, byte_we, resp_valid, addr_err;
    logic [31:0] addr, wdata, rdata;
    logic        req_valid1, req_ready1, word_we1, byte_we1, resp_valid1, addr_err1;
    logic [31:0] addr1, wdata1, rdata1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    data_mem_responder #(.AW(6), .LATENCY(3)) u_dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .addr(addr), .wdata(wdata), .word_we(word_we), .byte_we(byte_we),
        .resp_valid(resp_valid), .rdata(rdata), .addr_err(addr_err)
    );

    data_mem_responder #(.AW(6), .LATENCY(1)) u_dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid1), .req_ready(req_ready1),
        .addr(addr1), .wdata(wdata1), .word_we(word_we1), .byte_we(byte_we1),
        .resp_valid(resp_valid1), .rdata(rdata1), .addr_err(addr_err1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
        if (!req_ready) check_val({tag, " ready timeout"}, 32'(req_ready), 32'd1);
    endtask

    // Counts req_ready-low samples from the current one until it rises.
    task automatic count_clear(input string tag);
        int   n    = 0;
        logic seen = 1'b0;
        while (!req_ready && n < 200) begin
            if (resp_valid) seen = 1'b1;
            n++;
            tick();
        end
        check_val({tag, " clear cycles"}, 32'(n), 32'd64);
        check_val({tag, " no resp"}, 32'(seen), 32'd0);
    endtask

    task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic ww, input logic bw,
                          output logic [31:0] rd, output logic ae);
        int   lat;
        logic busy_ok;
        wait_ready(tag);
        addr = a; wdata = d; word_we = ww; byte_we = bw; req_valid = 1'b1;
        tick();
        // Scramble inputs after acceptance; the latched request must be used.
        req_valid = 1'b1; addr = 32'hFFFF_FFFF; wdata = ~d; word_we = 1'b1; byte_we = 1'b1;
        lat = 1;
        busy_ok = 1'b1;
        while (!resp_valid && lat < 20) begin
            if (req_ready) busy_ok = 1'b0;
            tick();
            lat++;
        end
        if (req_ready) busy_ok = 1'b0;
        req_valid = 1'b0; addr = 32'd0; wdata = 32'd0; word_we = 1'b0; byte_we = 1'b0;
        check_val({tag, " latency"}, 32'(lat), 32'd3);
        check_val({tag, " ready low"}, 32'(busy_ok), 32'd1);
        rd = rdata;
        ae = addr_err;
        tick();
        check_val({tag, " pulse"}, 32'(resp_valid), 32'd0);
        check_val({tag, " err clr"}, 32'(addr_err), 32'd0);
        check_val({tag, " rdata hold"}, rdata, rd);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ae;
        reset = 1'b1;
        req_valid = 1'b0; addr = 32'd0; wdata = 32'd0; word_we = 1'b0; byte_we = 1'b0;
        req_valid1 = 1'b0; addr1 = 32'd0; wdata1 = 32'd0; word_we1 = 1'b0; byte_we1 = 1'b0;

        // 1: reset, clear period, load of a cleared word
        tick();
        tick();
        reset = 1'b0;
        check_val("rst resp_valid", 32'(resp_valid), 32'd0);
        check_val("rst rdata", rdata, 32'd0);
        check_val("rst addr_err", 32'(addr_err), 32'd0);
        req_valid = 1'b1;
        count_clear("t1");
        req_valid = 1'b0;
        do_req("t1 load", 32'h0000_0010, 32'h0, 1'b0, 1'b0, rd, ae);
        check_val("t1 rdata", rd, 32'h0);
        check_val("t1 err", 32'(ae), 32'd0);

        // 2: word store then load
        do_req("t2 st", 32'h8, 32'hDEAD_BEEF, 1'b1, 1'b0, rd, ae);
        check_val("t2 st rdata", rd, 32'hDEAD_BEEF);
        do_req("t2 ld", 32'h8, 32'h0, 1'b0, 1'b0, rd, ae);
        check_val("t2 ld rdata", rd, 32'hDEAD_BEEF);

        // 3: byte lanes; upper wdata bits must be ignored
        do_req("t3 b0", 32'h20, 32'hFFFF_FF11, 1'b0, 1'b1, rd, ae);
        check_val("t3 b0 rdata", rd, 32'h0000_0011);
        do_req("t3 b1", 32'h21, 32'hFFFF_FF22, 1'b0, 1'b1, rd, ae);
        check_val("t3 b1 rdata", rd, 32'h0000_2211);
        do_req("t3 b2", 32'h22, 32'hFFFF_FF33, 1'b0, 1'b1, rd, ae);
        check_val("t3 b2 rdata", rd, 32'h0033_2211);
        do_req("t3 b3", 32'h23, 32'hFFFF_FF44, 1'b0, 1'b1, rd, ae);
        check_val("t3 b3 rdata", rd, 32'h4433_2211);
        do_req("t3 ld", 32'h20, 32'h0, 1'b0, 1'b0, rd, ae);
        check_val("t3 ld rdata", rd, 32'h4433_2211);
        do_req("t3 aa", 32'h21, 32'h0000_00AA, 1'b0, 1'b1, rd, ae);
        check_val("t3 aa rdata", rd, 32'h4433_AA11);

        // 4: word priority, out-of-range store
        do_req("t4 both", 32'h4, 32'h1234_5678, 1'b1, 1'b1, rd, ae);
        check_val("t4 both rdata", rd, 32'h1234_5678);
        do_req("t4 w0", 32'h0, 32'hCAFE_F00D, 1'b1, 1'b0, rd, ae);
        do_req("t4 oor", 32'h100, 32'h9999_9999, 1'b1, 1'b0, rd, ae);
        check_val("t4 oor err", 32'(ae), 32'd1);
        check_val("t4 oor rdata", rd, 32'h0);
        do_req("t4 ld0", 32'h0, 32'h0, 1'b0, 1'b0, rd, ae);
        check_val("t4 ld0 rdata", rd, 32'hCAFE_F00D);
        check_val("t4 ld0 err", 32'(ae), 32'd0);
        do_req("t4 ld4", 32'h4, 32'h0, 1'b0, 1'b0, rd, ae);
        check_val("t4 ld4 rdata", rd, 32'h1234_5678);

        // 5: reset during BUSY aborts the store and re-runs the clear
        do_req("t5 pre", 32'hC, 32'h7777_7777, 1'b1, 1'b0, rd, ae);
        check_val("t5 pre rdata", rd, 32'h7777_7777);
        wait_ready("t5");
        addr = 32'hC; wdata = 32'h5555_5555; word_we = 1'b1; req_valid = 1'b1;
        tick();
        req_valid = 1'b0; word_we = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("t5 rst rdata", rdata, 32'd0);
        count_clear("t5");
        do_req("t5 ldC", 32'hC, 32'h0, 1'b0, 1'b0, rd, ae);
        check_val("t5 ldC rdata", rd, 32'h0);
        do_req("t5 ld8", 32'h8, 32'h0, 1'b0, 1'b0, rd, ae);
        check_val("t5 ld8 rdata", rd, 32'h0);

        // 6: LATENCY=1 instance, req_valid held high
        begin
            int n = 0;
            while (!req_ready1 && n < 200) begin
                tick();
                n++;
            end
            check_val("t6 ready", 32'(req_ready1), 32'd1);
            req_valid1 = 1'b1;
            word_we1   = 1'b1;
            for (int k = 0; k < 4; k++) begin
                addr1  = 32'(4 * k);
                wdata1 = 32'hA000_0000 + 32'(k);
                check_val("t6 ready hi", 32'(req_ready1), 32'd1);
                check_val("t6 resp lo", 32'(resp_valid1), 32'd0);
                tick();
                check_val("t6 resp hi", 32'(resp_valid1), 32'd1);
                check_val("t6 ready lo", 32'(req_ready1), 32'd0);
                check_val("t6 rdata", rdata1, 32'hA000_0000 + 32'(k));
                tick();
            end
            req_valid1 = 1'b0;
            word_we1   = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the memory side of the CPU load/store interface.
- Services word loads, word stores and byte stores through a valid/ready request and a one-cycle response strobe, with configurable access latency.
- Replaces the single-cycle data memory when building the stalling, multi-cycle machine; the CPU freezes its PC until resp_valid.
- Also owns zero-initialisation of its storage after reset.

Parameters:
- AW, 6: word-address width; storage is 2^AW 32-bit words.
- LATENCY, 3: cycles from request acceptance to response; legal range 1..15.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  CPU presents a request this cycle.
- req_ready  output  1  responder can accept a request this cycle.
- addr  input  32  byte address.
- wdata  input  32  store data.
- word_we  input  1  request is a word store.
- byte_we  input  1  request is a byte store.
- resp_valid  output  1  one-cycle pulse: request complete.
- rdata  output  32  word read at the completed address; valid when resp_valid.
- addr_err  output  1  qualifies resp_valid: address out of range.

Behaviour:
- Clock and reset: one clock (clock); reset is synchronous and active-high.
- Reset values: req_ready=0, resp_valid=0, rdata=0, addr_err=0, state=CLEAR, clear index=0.
- Reset mid-operation: any latched request is aborted, with no write and no response; the FSM restarts CLEAR.
- State machine states: CLEAR, IDLE, BUSY, RESP.
- CLEAR:
  - Writes zero to word[idx] each cycle and increments idx.
  - After writing word 2^AW-1, goes to IDLE.
  - First cycle with req_ready=1 is exactly 2^AW cycles after the last cycle reset was high.
  - req_valid is ignored during CLEAR.
- IDLE:
  - req_ready=1 only in IDLE; acceptance means req_valid&&req_ready at a rising edge.
  - On acceptance (cycle T): latch addr, wdata, word_we, byte_we.
  - LATENCY=1: go directly to RESP.
  - Otherwise: go to BUSY with counter=LATENCY-2.
- BUSY: decrements the counter; moves to RESP on the edge where counter==0.
- Response timing: resp_valid is high in cycle T+LATENCY only, then IDLE.
  - Maximum throughput is one request per LATENCY+1 cycles.
  - A request cannot be accepted in the RESP cycle.
- Commit: on the edge entering RESP:
  - Range check: widx=latched addr[AW+1:2]; in range iff addr[31:AW+2]==0.
  - In range:
    - word_we: word[widx]<=wdata; addr[1:0] ignored.
    - else byte_we: lane addr[1:0] (0=bits 7:0 … 3=bits 31:24) <= wdata[7:0]; other lanes unchanged.
    - Both asserted: word store takes priority.
    - Neither asserted: load; no write.
    - rdata <= word[widx] value after the commit (read-after-write for stores).
  - Out of range: no write, rdata<=0, addr_err<=1.
- Outside RESP: addr_err=0 and resp_valid=0; rdata holds its last value.
- Request inputs changing while not in IDLE have no effect.

Test Plan:
1. Reset held 2 cycles, then released -> req_ready low for exactly 64 cycles (AW=6), then high; a load of 0x0000_0010 returns rdata=0.
2. Word store 0xDEADBEEF to 0x8, accepted at cycle T -> resp_valid only at T+3 with rdata=0xDEADBEEF; req_ready low T+1..T+3; a load of 0x8 then returns 0xDEADBEEF.
3. Byte stores 0x11, 0x22, 0x33, 0x44 to 0x20..0x23 over a zeroed word -> load 0x20 returns 0x44332211; a further byte store 0xAA to 0x21 returns 0x4433AA11.
4. Store with word_we=byte_we=1, wdata=0x12345678, addr 0x4 -> full word 0x12345678 written; an out-of-range store to 0x100 (AW=6) -> addr_err=1 with resp_valid, rdata=0, word 0 unchanged.
5. reset asserted in the BUSY cycle of a store to 0xC -> no resp_valid; CLEAR re-runs; 0xC reads 0 afterwards.
6. LATENCY=1 build: back-to-back req_valid held high -> acceptances every 2 cycles, each resp_valid exactly 1 cycle after its acceptance.
